traffic_intersection_ctrl: RTL and testbench

- N-way traffic intersection controller, successor to the single-approach traffic_lights block.
- Serves NUM_WAYS approaches in round-robin: one GREEN phase per approach, then YELLOW, then an all-red clearance phase.
- Adds sticky per-approach pedestrian requests that lengthen the green phase, and a night flashing-yellow mode.
- Sits between the board-level request/mode inputs and the lamp drivers.

---
 rtl/traffic_pkg.sv | 23 ++
 rtl/traffic_phase_timer.sv | 35 +++
 rtl/traffic_intersection_ctrl.sv | 175 +++++++++++++++++
 tb/tb_traffic_intersection_ctrl.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// Shared types and defaults for the traffic intersection controller.
// Phase encoding, default timer lengths and the way-index width helper.
package traffic_pkg;

    typedef enum logic [1:0] {
        AllRed,
        Green,
        Yellow,
        Flash
    } phase_e;

    localparam int unsigned DefGreenTimer  = 6;
    localparam int unsigned DefYellowTimer = 2;
    localparam int unsigned DefRedTimer    = 8;
    localparam int unsigned DefPedTimer    = 10;
    localparam int unsigned DefCntW        = 16;

    // A single approach index still needs one bit to keep the port legal.
    function automatic int unsigned way_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/traffic_phase_timer.sv
// Loadable down counter; expired is high while the count reads zero.
// Holds at zero until reloaded.
module traffic_phase_timer #(
    parameter int unsigned CNT_W     = 16,
    parameter int unsigned RESET_VAL = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             expired
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= CNT_W'(RESET_VAL);
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (cnt_q == '0);

endmodule

// File: rtl/traffic_intersection_ctrl.sv
// N-way round-robin intersection controller with sticky pedestrian requests
// and a night flashing-yellow mode. All lamp outputs are registered.
module traffic_intersection_ctrl
    import traffic_pkg::*;
#(
    parameter int unsigned NUM_WAYS    = 2,
    parameter int unsigned GREENTIMER  = DefGreenTimer,
    parameter int unsigned YELLOWTIMER = DefYellowTimer,
    parameter int unsigned REDTIMER    = DefRedTimer,
    parameter int unsigned PEDTIMER    = DefPedTimer,
    parameter int unsigned CNT_W       = DefCntW
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [NUM_WAYS-1:0]                 ped_req,
    input  logic                                flash_mode,
    output logic [NUM_WAYS-1:0]                 red,
    output logic [NUM_WAYS-1:0]                 yellow,
    output logic [NUM_WAYS-1:0]                 green,
    output logic [NUM_WAYS-1:0]                 ped_walk,
    output logic [way_width(NUM_WAYS)-1:0]      active_way
);

    localparam int unsigned WayW     = way_width(NUM_WAYS);
    localparam int unsigned PedGreen = (PEDTIMER > GREENTIMER) ? PEDTIMER : GREENTIMER;

    localparam logic [CNT_W-1:0] GreenLoad  = CNT_W'(GREENTIMER - 1);
    localparam logic [CNT_W-1:0] PedLoad    = CNT_W'(PedGreen - 1);
    localparam logic [CNT_W-1:0] YellowLoad = CNT_W'(YELLOWTIMER - 1);
    localparam logic [CNT_W-1:0] RedLoad    = CNT_W'(REDTIMER - 1);

    phase_e                state_q, state_d;
    logic [WayW-1:0]       way_q, way_d, next_way;
    logic [NUM_WAYS-1:0]   ped_q, ped_d;
    logic                  walk_q, walk_d;
    logic                  lit_q, lit_d;
    logic                  load;
    logic [CNT_W-1:0]      load_val;
    logic                  expired;
    logic [NUM_WAYS-1:0]   red_d, yellow_d, green_d, walk_out_d;

    traffic_phase_timer #(
        .CNT_W     (CNT_W),
        .RESET_VAL (REDTIMER - 1)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .load_val (load_val),
        .expired  (expired)
    );

    assign next_way = (way_q == WayW'(NUM_WAYS - 1)) ? '0 : way_q + 1'b1;

    always_comb begin
        state_d  = state_q;
        way_d    = way_q;
        walk_d   = walk_q;
        lit_d    = lit_q;
        ped_d    = ped_q;
        load     = 1'b0;
        load_val = RedLoad;
        unique case (state_q)
            AllRed: begin
                if (expired) begin
                    load = 1'b1;
                    if (flash_mode) begin
                        state_d  = Flash;
                        lit_d    = 1'b1;
                        load_val = YellowLoad;
                    end else begin
                        state_d = Green;
                        way_d   = next_way;
                        if (ped_q[next_way]) begin
                            ped_d[next_way] = 1'b0;
                            walk_d          = 1'b1;
                            load_val        = PedLoad;
                        end else begin
                            walk_d   = 1'b0;
                            load_val = GreenLoad;
                        end
                    end
                end
            end
            Green: begin
                // Flash request truncates green immediately.
                if (flash_mode || expired) begin
                    state_d  = Yellow;
                    walk_d   = 1'b0;
                    load     = 1'b1;
                    load_val = YellowLoad;
                end
            end
            Yellow: begin
                if (expired) begin
                    load = 1'b1;
                    if (flash_mode) begin
                        state_d  = Flash;
                        lit_d    = 1'b1;
                        load_val = YellowLoad;
                    end else begin
                        state_d  = AllRed;
                        load_val = RedLoad;
                    end
                end
            end
            Flash: begin
                if (!flash_mode) begin
                    state_d  = AllRed;
                    load     = 1'b1;
                    load_val = RedLoad;
                end else if (expired) begin
                    lit_d    = ~lit_q;
                    load     = 1'b1;
                    load_val = YellowLoad;
                end
            end
            default: state_d = AllRed;
        endcase
        // Requests seen at green entry stay latched for the next service.
        if (state_q != Flash) begin
            ped_d = ped_d | ped_req;
        end
    end

    always_comb begin
        red_d      = '1;
        yellow_d   = '0;
        green_d    = '0;
        walk_out_d = '0;
        unique case (state_d)
            Flash: begin
                red_d    = '0;
                yellow_d = {NUM_WAYS{lit_d}};
            end
            Green: begin
                red_d[way_d]      = 1'b0;
                green_d[way_d]    = 1'b1;
                walk_out_d[way_d] = walk_d;
            end
            Yellow: begin
                red_d[way_d]    = 1'b0;
                yellow_d[way_d] = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= AllRed;
            way_q      <= WayW'(NUM_WAYS - 1);
            ped_q      <= '0;
            walk_q     <= 1'b0;
            lit_q      <= 1'b0;
            red        <= '1;
            yellow     <= '0;
            green      <= '0;
            ped_walk   <= '0;
            active_way <= WayW'(NUM_WAYS - 1);
        end else begin
            state_q    <= state_d;
            way_q      <= way_d;
            ped_q      <= ped_d;
            walk_q     <= walk_d;
            lit_q      <= lit_d;
            red        <= red_d;
            yellow     <= yellow_d;
            green      <= green_d;
            ped_walk   <= walk_out_d;
            active_way <= way_d;
        end
    end

endmodule

// File: tb/tb_traffic_intersection_ctrl.sv
// Bench for traffic_intersection_ctrl (3 ways): directed scenarios plus random
// stimulus, every cycle compared against a phase/remaining-time reference model.
module tb_traffic_intersection_ctrl;

    localparam int N = 3;
    localparam int W = 2;
    localparam int G = 6;
    localparam int Y = 2;
    localparam int R = 8;
    localparam int P = 10;
    localparam int PG = (P > G) ? P : G;

    localparam int PH_AR = 0;
    localparam int PH_GR = 1;
    localparam int PH_YE = 2;
    localparam int PH_FL = 3;

    logic         clk = 1'b0;
    logic         rst;
    logic         flash_mode;
    logic [N-1:0] ped_req;
    logic [N-1:0] red, yellow, green, ped_walk;
    logic [W-1:0] active_way;

    always #5 clk = ~clk;

    traffic_intersection_ctrl #(
        .NUM_WAYS    (N),
        .GREENTIMER  (G),
        .YELLOWTIMER (Y),
        .REDTIMER    (R),
        .PEDTIMER    (P),
        .CNT_W       (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ped_req    (ped_req),
        .flash_mode (flash_mode),
        .red        (red),
        .yellow     (yellow),
        .green      (green),
        .ped_walk   (ped_walk),
        .active_way (active_way)
    );

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    // Reference model: phase, cycles left in it, owning way, pending requests.
    int m_phase, m_left, m_way, m_walk, m_lit;
    bit m_pend[N];

    task automatic model_edge(input bit r, input logic [N-1:0] p, input bit fl);
        int old;
        old = m_phase;
        if (r) begin
            m_phase = PH_AR; m_left = R; m_way = N - 1; m_walk = 0; m_lit = 0;
            for (int i = 0; i < N; i++) m_pend[i] = 0;
            return;
        end
        case (m_phase)
            PH_AR: begin
                if (m_left == 1) begin
                    if (fl) begin
                        m_phase = PH_FL; m_lit = 1; m_left = Y;
                    end else begin
                        m_way = (m_way + 1) % N;
                        m_phase = PH_GR;
                        if (m_pend[m_way]) begin
                            m_pend[m_way] = 0; m_walk = 1; m_left = PG;
                        end else begin
                            m_walk = 0; m_left = G;
                        end
                    end
                end else m_left--;
            end
            PH_GR: begin
                if (fl || m_left == 1) begin
                    m_phase = PH_YE; m_left = Y; m_walk = 0;
                end else m_left--;
            end
            PH_YE: begin
                if (m_left == 1) begin
                    if (fl) begin
                        m_phase = PH_FL; m_lit = 1; m_left = Y;
                    end else begin
                        m_phase = PH_AR; m_left = R;
                    end
                end else m_left--;
            end
            default: begin
                if (!fl) begin
                    m_phase = PH_AR; m_left = R;
                end else if (m_left == 1) begin
                    m_lit = 1 - m_lit; m_left = Y;
                end else m_left--;
            end
        endcase
        if (old != PH_FL)
            for (int i = 0; i < N; i++) if (p[i]) m_pend[i] = 1;
    endtask

    function automatic logic [4*N+W-1:0] expect_vec();
        logic [N-1:0] er, ey, eg, ew;
        logic [W-1:0] ea;
        er = '0; ey = '0; eg = '0; ew = '0;
        for (int i = 0; i < N; i++) begin
            if (m_phase == PH_FL) ey[i] = (m_lit != 0);
            else if (m_phase == PH_GR && i == m_way) begin
                eg[i] = 1'b1; ew[i] = (m_walk != 0);
            end else if (m_phase == PH_YE && i == m_way) ey[i] = 1'b1;
            else er[i] = 1'b1;
        end
        ea = W'(m_way);
        return {er, ey, eg, ew, ea};
    endfunction

    task automatic step(input bit r, input logic [N-1:0] p, input bit fl, input string tag);
        logic [4*N+W-1:0] got, exp;
        rst = r; ped_req = p; flash_mode = fl;
        @(posedge clk);
        model_edge(r, p, fl);
        #1;
        cyc = r ? 0 : cyc + 1;
        got = {red, yellow, green, ped_walk, active_way};
        exp = expect_vec();
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, got, exp);
        end
    endtask

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, got, exp);
        end
    endtask

    task automatic do_reset();
        step(1'b1, '0, 1'b0, "reset");
        step(1'b1, '0, 1'b0, "reset");
    endtask

    initial begin
        rst = 1'b1; ped_req = '0; flash_mode = 1'b0;
        model_edge(1'b1, '0, 1'b0);

        // Plain round-robin including wrap 2 -> 0.
        do_reset();
        chk("reset_red", 8'(red), 8'b111);
        chk("reset_way", 8'(active_way), 8'd2);
        for (int k = 0; k < 60; k++) begin
            step(1'b0, '0, 1'b0, "rr");
            if (cyc == 8)  chk("green0_start", 8'(green), 8'b001);
            if (cyc == 14) chk("yellow0", 8'(yellow), 8'b001);
            if (cyc == 24) chk("green1_start", 8'(green), 8'b010);
            if (cyc == 40) chk("green2_start", 8'(green), 8'b100);
            if (cyc == 56) chk("wrap_way", 8'(active_way), 8'd0);
        end

        // Pedestrian request for way 1 lengthens its next green.
        do_reset();
        for (int k = 0; k < 100; k++) begin
            step(1'b0, (cyc == 3) ? 3'b010 : 3'b000, 1'b0, "ped1");
            if (cyc == 33) chk("ped_walk_end", 8'(ped_walk), 8'b010);
            if (cyc == 34) chk("ped_yellow", 8'(yellow), 8'b010);
        end

        // Request during own green is deferred to the next green.
        do_reset();
        for (int k = 0; k < 80; k++) begin
            step(1'b0, (cyc == 10) ? 3'b001 : 3'b000, 1'b0, "ped_own");
            if (cyc == 13) chk("own_no_walk", 8'(ped_walk), 8'b000);
        end

        // Flash during green, then release.
        do_reset();
        for (int k = 0; k < 50; k++) begin
            step(1'b0, '0, (cyc >= 10 && cyc < 25), "flash_gr");
            if (cyc == 11) chk("flash_yellow", 8'(yellow), 8'b001);
            if (cyc == 13) chk("flash_on", 8'(yellow), 8'b111);
            if (cyc == 15) chk("flash_off", 8'(yellow), 8'b000);
        end

        // Flash requested during all-red; pedestrian pulses ignored in flash.
        do_reset();
        for (int k = 0; k < 50; k++)
            step(1'b0, (cyc == 12) ? 3'b001 : 3'b000, (cyc >= 3 && cyc < 20), "flash_ar");

        // Reset mid-green discards a pending latch.
        do_reset();
        for (int k = 0; k < 11; k++) step(1'b0, (cyc == 2) ? 3'b010 : 3'b000, 1'b0, "pre_rst");
        do_reset();
        for (int k = 0; k < 40; k++) begin
            step(1'b0, '0, 1'b0, "post_rst");
            if (cyc == 24) chk("latch_dropped", 8'(ped_walk), 8'b000);
        end

        // Random traffic.
        begin
            bit fl;
            fl = 1'b0;
            for (int k = 0; k < 3000; k++) begin
                logic [N-1:0] p;
                p = '0;
                for (int i = 0; i < N; i++) p[i] = ($urandom_range(0, 9) == 0);
                if ($urandom_range(0, 39) == 0) fl = ~fl;
                step(($urandom_range(0, 299) == 0), p, fl, "random");
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
